// File: rtl/nios_system_switch_poller_pkg.sv
// rtl/nios_system_switch_poller_pkg.sv - register map, field positions and FSM states for the switch poller
package nios_system_switch_poller_pkg;

  localparam logic [1:0] ADDR_STABLE = 2'd0;
  localparam logic [1:0] ADDR_EVENT  = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int STATUS_OVF_BIT  = 8;
  localparam int CTRL_IRQ_EN_BIT = 0;
  localparam int ENTRY_VALID_BIT = 31;
  localparam int ENTRY_DIFF_LSB  = 8;
  localparam int CNT_W           = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CAPTURE,
    ST_EVAL
  } poll_state_t;

  function automatic logic [31:0] make_entry(input logic [7:0] old_v, input logic [7:0] new_v);
    logic [31:0] e;
    e = '0;
    e[ENTRY_VALID_BIT] = 1'b1;
    e[ENTRY_DIFF_LSB +: 8] = old_v ^ new_v;
    e[7:0] = new_v;
    return e;
  endfunction

endpackage

// File: rtl/nios_system_switch_poller_if.sv
// rtl/nios_system_switch_poller_if.sv - CPU slave register bus and interrupt between CPU and poller
interface nios_system_switch_poller_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, irq
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, irq
  );
endinterface

// File: rtl/nios_system_switch_poller_fifo.sv
// rtl/nios_system_switch_poller_fifo.sv - switch event FIFO; a push while full only lands if a pop frees a slot
module nios_system_switch_poller_fifo
  import nios_system_switch_poller_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [31:0]      din,
  output logic [31:0]      head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/nios_system_switch_poller.sv
// rtl/nios_system_switch_poller.sv - debounced 8-bit switch poller with event FIFO and CPU slave
// SWITCH_POLLER_IRQ_EN enables the irq output and the control register; otherwise irq is 0 and addr3 reads 0.
module nios_system_switch_poller
  import nios_system_switch_poller_pkg::*;
#(
  parameter int POLL_DIV   = 50000,
  parameter int DEBOUNCE_N = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  sw_address,
  input  logic [31:0] sw_readdata,
  nios_system_switch_poller_if.slave avs
);

  localparam int              PRESC_W      = 20;
  localparam logic [PRESC_W-1:0] PRESC_RELOAD = PRESC_W'(POLL_DIV - 3);
  localparam logic [3:0]      DB_N         = 4'(DEBOUNCE_N);

  poll_state_t        state;
  logic [PRESC_W-1:0] presc;
  logic [3:0]         match_cnt;
  logic [3:0]         cnt_next;
  logic [7:0]         sample;
  logic [7:0]         prev_sample;
  logic [7:0]         stable;
  logic               primed;
  logic               overflow;
  logic               irq_en;
  logic [31:0]        readdata_q;
  logic [31:0]        rd_mux;
  logic               match;
  logic               accept;
  logic               push;
  logic               pop_req;
  logic               ovf_set;
  logic [31:0]        fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               unused_bits;

  assign sw_address = 2'd0;

  // A zero counter means no sample has been seen yet, so the first one never counts as a repeat.
  always_comb begin
    match = (match_cnt != 4'd0) && (sample == prev_sample);
    if (!match)
      cnt_next = 4'd1;
    else if (match_cnt >= DB_N)
      cnt_next = DB_N;
    else
      cnt_next = match_cnt + 4'd1;
    accept = (state == ST_EVAL) && (cnt_next == DB_N) && (!primed || (sample != stable));
    push   = accept && primed;
  end

  assign pop_req = avs.avs_read && (avs.avs_address == ADDR_EVENT);
  assign ovf_set = push && fifo_full && !pop_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      presc       <= PRESC_RELOAD;
      match_cnt   <= 4'd0;
      sample      <= 8'd0;
      prev_sample <= 8'd0;
      stable      <= 8'd0;
      primed      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (presc == PRESC_W'(1)) begin
            presc <= PRESC_RELOAD;
            state <= ST_ADDR;
          end else begin
            presc <= presc - PRESC_W'(1);
          end
        end
        ST_ADDR:    state <= ST_CAPTURE;
        ST_CAPTURE: begin
          sample <= sw_readdata[7:0];
          state  <= ST_EVAL;
        end
        ST_EVAL: begin
          match_cnt   <= cnt_next;
          prev_sample <= sample;
          if (accept) begin
            stable <= sample;
            primed <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  nios_system_switch_poller_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop_req),
    .din   (make_entry(stable, sample)),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rd_mux = '0;
    case (avs.avs_address)
      ADDR_STABLE: rd_mux[7:0] = stable;
      ADDR_EVENT:  rd_mux = fifo_empty ? 32'd0 : fifo_head;
      ADDR_STATUS: begin
        rd_mux[STATUS_OVF_BIT] = overflow;
        rd_mux[CNT_W-1:0]      = fifo_count;
      end
      ADDR_CTRL:   rd_mux[CTRL_IRQ_EN_BIT] = irq_en;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= 32'd0;
      overflow   <= 1'b0;
    end else begin
      if (avs.avs_read) readdata_q <= rd_mux;
      if (avs.avs_write && (avs.avs_address == ADDR_STATUS) && avs.avs_writedata[STATUS_OVF_BIT])
        overflow <= 1'b0;
      if (ovf_set) overflow <= 1'b1;
    end
  end

  assign avs.avs_readdata = readdata_q;

`ifdef SWITCH_POLLER_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset)
      irq_en <= 1'b0;
    else if (avs.avs_write && (avs.avs_address == ADDR_CTRL))
      irq_en <= avs.avs_writedata[CTRL_IRQ_EN_BIT];
  end

  assign avs.irq = irq_en && ((fifo_count != '0) || overflow);
  assign unused_bits = ^{sw_readdata[31:8], avs.avs_writedata[31:9], avs.avs_writedata[7:1]};
`else
  assign irq_en  = 1'b0;
  assign avs.irq = 1'b0;
  assign unused_bits = ^{sw_readdata[31:8], avs.avs_writedata[31:9], avs.avs_writedata[7:0]};
`endif

endmodule

// File: tb/tb_nios_system_switch_poller.sv
// tb/tb_nios_system_switch_poller.sv - directed scoreboard bench for the switch poller (POLL_DIV=8)
module tb_nios_system_switch_poller;
  import nios_system_switch_poller_pkg::*;

`ifdef SWITCH_POLLER_IRQ_EN
  localparam bit IRQ_BUILT = 1'b1;
`else
  localparam bit IRQ_BUILT = 1'b0;
`endif
  localparam int SETTLE = 48;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  sw_address;
  logic [31:0] sw_readdata = 32'd0;
  logic [7:0]  sw_val = 8'd0;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mq[$];
  logic [7:0]  stable_m = 8'd0;
  bit          ovf_m = 1'b0;
  bit          irq_en_m = 1'b0;

  nios_system_switch_poller_if bus ();

  nios_system_switch_poller #(
    .POLL_DIV   (8),
    .DEBOUNCE_N (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_address  (sw_address),
    .sw_readdata (sw_readdata),
    .avs         (bus)
  );

  always #5 clk = ~clk;

  // Switch PIO model: registered read data, one cycle behind the switch value.
  always @(posedge clk) sw_readdata <= {24'd0, sw_val};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] entry_m(input logic [7:0] o, input logic [7:0] n);
    return {1'b1, 15'd0, o ^ n, n};
  endfunction

  function automatic logic [31:0] status_m();
    return {23'd0, ovf_m, 3'd0, 5'(mq.size())};
  endfunction

  function automatic logic [31:0] irq_m();
    return {31'd0, IRQ_BUILT && irq_en_m && ((mq.size() != 0) || ovf_m)};
  endfunction

  task automatic cpu_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.avs_read = 1'b0;
    check(tag, bus.avs_readdata, exp_q.pop_front());
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic read_event(input string tag);
    logic [31:0] e;
    e = (mq.size() != 0) ? mq.pop_front() : 32'd0;
    cpu_read(ADDR_EVENT, e, tag);
  endtask

  task automatic set_sw(input logic [7:0] v);
    sw_val = v;
    if (v != stable_m) begin
      if (mq.size() < 4) mq.push_back(entry_m(stable_m, v));
      else ovf_m = 1'b1;
      stable_m = v;
    end
    repeat (SETTLE) @(negedge clk);
  endtask

  initial begin
    bit found;
    bus.avs_address   = 2'd0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = 32'd0;

    repeat (3) @(negedge clk);
    check("reset_readdata", bus.avs_readdata, 32'd0);
    check("reset_irq", {31'd0, bus.irq}, 32'd0);
    check("sw_address", {30'd0, sw_address}, 32'd0);
    reset = 1'b0;

    // First acceptance of 0x00 only primes the stable value.
    repeat (SETTLE) @(negedge clk);
    cpu_read(ADDR_STABLE, 32'd0, "prime_stable");
    cpu_read(ADDR_STATUS, status_m(), "prime_status");
    read_event("empty_pop");
    cpu_read(ADDR_STATUS, status_m(), "empty_pop_status");

    set_sw(8'h05);
    cpu_read(ADDR_STATUS, status_m(), "ev05_status");
    check("ev05_model", mq[0], 32'h8000_0505);
    read_event("ev05_pop");
    cpu_read(ADDR_STATUS, status_m(), "ev05_drained");
    cpu_read(ADDR_STABLE, 32'h05, "ev05_stable");

    set_sw(8'h00);
    read_event("ev00_pop");

    // Bounce: each sample differs from the previous one, so the counter never builds up.
    for (int i = 0; i < 12; i++) begin
      sw_val = i[0] ? 8'h00 : 8'h05;
      repeat (8) @(negedge clk);
    end
    sw_val = 8'h00;
    repeat (SETTLE) @(negedge clk);
    cpu_read(ADDR_STABLE, 32'h00, "bounce_stable");
    cpu_read(ADDR_STATUS, status_m(), "bounce_status");

    cpu_write(ADDR_STABLE, 32'hFF);
    cpu_read(ADDR_STABLE, 32'h00, "addr0_write_ignored");

    set_sw(8'h11);
    set_sw(8'h22);
    set_sw(8'h33);
    set_sw(8'h44);
    set_sw(8'h55);
    cpu_read(ADDR_STATUS, 32'h104, "overflow_status");
    cpu_write(ADDR_STATUS, 32'h100);
    ovf_m = 1'b0;
    cpu_read(ADDR_STATUS, 32'h004, "overflow_cleared");

    cpu_write(ADDR_CTRL, 32'h1);
    irq_en_m = IRQ_BUILT;
    check("irq_pending", {31'd0, bus.irq}, irq_m());
    cpu_read(ADDR_CTRL, {31'd0, irq_en_m}, "ctrl_read");
    for (int i = 0; i < 4; i++) read_event("drain_pop");
    check("irq_drained", {31'd0, bus.irq}, irq_m());
    cpu_read(ADDR_STATUS, 32'h0, "drain_status");

    set_sw(8'h66);
    check("irq_one_event", {31'd0, bus.irq}, irq_m());
    cpu_write(ADDR_CTRL, 32'h0);
    irq_en_m = 1'b0;
    check("irq_disabled", {31'd0, bus.irq}, 32'd0);
    read_event("ev66_pop");

    cpu_write(ADDR_CTRL, 32'h1);
    irq_en_m = IRQ_BUILT;
    set_sw(8'h3C);
    check("irq_before_reset", {31'd0, bus.irq}, irq_m());

    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dut.state == ST_CAPTURE) begin
        found = 1'b1;
        break;
      end
    end
    check("capture_reached", {31'd0, found}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    mq.delete();
    ovf_m    = 1'b0;
    irq_en_m = 1'b0;
    stable_m = 8'd0;
    check("midreset_readdata", bus.avs_readdata, 32'd0);
    check("midreset_irq", {31'd0, bus.irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cpu_read(ADDR_STATUS, 32'd0, "midreset_status");
    cpu_read(ADDR_CTRL, 32'd0, "midreset_ctrl");

    // Post-reset first acceptance of 0x3C primes without an event.
    repeat (SETTLE) @(negedge clk);
    stable_m = 8'h3C;
    cpu_read(ADDR_STABLE, {24'd0, stable_m}, "reprime_stable");
    cpu_read(ADDR_STATUS, status_m(), "reprime_status");
    read_event("reprime_empty_pop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
